// File: rtl/vx_lsu_prefetch_sched.sv
// vx_lsu_prefetch_sched: shares the LSU dcache request port between demand requests and next-line prefetches
// Build option PF_DEDUP_EN: silently discard candidates whose line is already queued or was the last one issued.
module vx_lsu_prefetch_sched #(
    parameter int LINE_SIZE    = 64,
    parameter int PFQ_SIZE     = 4,
    parameter int PF_MAX_OUT   = 4,
    parameter int PF_TIMEOUT   = 16,
    parameter int STRIDE_LINES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pf_enable,
    input  logic             i_dmd_valid,
    output logic             o_dmd_ready,
    input  logic             i_dmd_is_load,
    input  logic [31:0]      i_dmd_addr,
    output logic             o_req_valid,
    input  logic             i_req_ready,
    output logic             o_req_is_pf,
    output logic [29:0]      o_req_pf_addr,
    input  logic             i_pf_rsp_valid,
    output logic [CNT_W-1:0] o_pf_issued_cnt,
    output logic [CNT_W-1:0] o_pf_drop_cnt
);
    localparam int LB = $clog2(LINE_SIZE);
    localparam int LW = 32 - LB;
    localparam int PW = $clog2(PFQ_SIZE);
    localparam int CW = $clog2(PF_MAX_OUT + 1);
    localparam int AW = $clog2(PF_TIMEOUT);

    logic [LW-1:0]    r_q [PFQ_SIZE];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [PW:0]      r_cnt;
    logic [AW-1:0]    r_age;
    logic [CW-1:0]    r_credits;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_drop;

    logic          w_empty;
    logic          w_full;
    logic          w_pf_elig;
    logic          w_pf_fire;
    logic          w_dmd_fire;
    logic          w_train;
    logic          w_timeout;
    logic          w_pop;
    logic          w_dup;
    logic          w_push;
    logic          w_full_drop;
    logic          w_rsp;
    logic [LW-1:0] w_cand;
    logic [LW-1:0] w_head;

    assign w_empty     = r_cnt == '0;
    assign w_full      = r_cnt == (PW+1)'(PFQ_SIZE);
    assign w_pf_elig   = ~w_empty & (r_credits != '0) & i_pf_enable;
    assign o_req_valid = i_reset & (i_dmd_valid | w_pf_elig);
    assign o_dmd_ready = i_reset & i_req_ready & i_dmd_valid;
    assign o_req_is_pf = i_reset & ~i_dmd_valid & w_pf_elig;
    assign w_head      = r_q[r_rd];
    assign o_req_pf_addr = 30'({w_head, {LB{1'b0}}} >> 2);

    assign w_pf_fire   = o_req_valid & i_req_ready & o_req_is_pf;
    assign w_dmd_fire  = i_dmd_valid & o_dmd_ready;
    assign w_train     = w_dmd_fire & i_dmd_is_load & i_pf_enable;
    assign w_cand      = LW'((i_dmd_addr >> LB) + 32'(STRIDE_LINES));
    // a fire in the timeout cycle wins, so the head is only aged out when it did not issue
    assign w_timeout   = i_pf_enable & ~w_empty & ~w_pf_fire & (r_age == AW'(PF_TIMEOUT - 1));
    assign w_pop       = w_pf_fire | w_timeout;
    assign w_push      = w_train & ~w_dup & (~w_full | w_pop);
    assign w_full_drop = w_train & ~w_dup & w_full & ~w_pop;
    // a response with nothing outstanding is stale and must not mint a credit
    assign w_rsp       = i_pf_rsp_valid & (r_credits != CW'(PF_MAX_OUT));

    assign o_pf_issued_cnt = r_issued;
    assign o_pf_drop_cnt   = r_drop;

`ifdef PF_DEDUP_EN
    logic [LW-1:0] r_last_line;

    // candidate matches the last issued line or any occupied FIFO slot
    always_comb begin
        w_dup = w_cand == r_last_line;
        for (int i = 0; i < PFQ_SIZE; i++)
            w_dup = w_dup | ((r_q[i] == w_cand) & ({1'b0, PW'(i) - r_rd} < r_cnt));
    end

    // remember the line of every issued prefetch
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_last_line <= '0;
        else if (w_pf_fire)
            r_last_line <= w_head;
    end
`else
    assign w_dup = 1'b0;
`endif

    // candidate FIFO and head age; disabling prefetch flushes without counting drops
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_age <= '0;
        end else if (!i_pf_enable) begin
            r_rd  <= r_wr;
            r_cnt <= '0;
            r_age <= '0;
        end else begin
            if (w_push) begin
                r_q[r_wr] <= w_cand;
                r_wr      <= r_wr + PW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + PW'(1);
            r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
            r_age <= (w_pop || w_empty) ? '0 : r_age + AW'(1);
        end
    end

    // outstanding-prefetch credits and saturating status counters
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_credits <= CW'(PF_MAX_OUT);
            r_issued  <= '0;
            r_drop    <= '0;
        end else begin
            r_credits <= r_credits - CW'(w_pf_fire) + CW'(w_rsp);
            r_issued  <= r_issued + CNT_W'(w_pf_fire & ~&r_issued);
            r_drop    <= r_drop + CNT_W'((w_full_drop | w_timeout) & ~&r_drop);
        end
    end
endmodule
